// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - flag bit indices, branch condition codes and datapath defaults for the execute result stage
package simple_pkg;

  localparam int DATA_W_DEFAULT = 16;

  // Positions of the ALU flags inside the {S,Z,C,V} nibble
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    BR_ALWAYS = 3'd0,
    BR_EQ     = 3'd1,
    BR_NE     = 3'd2,
    BR_LT     = 3'd3,
    BR_LE     = 3'd4,
    BR_CS     = 3'd5,
    BR_CC     = 3'd6,
    BR_NEVER  = 3'd7
  } br_cond_e;

  // True when the condition code is satisfied by the given flag nibble
  function automatic logic br_cond_true(input logic [2:0] cond, input logic [3:0] flags);
    logic s;
    logic z;
    logic c;
    logic v;
    logic hit;
    s   = flags[FLAG_S];
    z   = flags[FLAG_Z];
    c   = flags[FLAG_C];
    v   = flags[FLAG_V];
    hit = 1'b0;
    case (cond)
      BR_ALWAYS: hit = 1'b1;
      BR_EQ:     hit = z;
      BR_NE:     hit = !z;
      BR_LT:     hit = s ^ v;
      BR_LE:     hit = z | (s ^ v);
      BR_CS:     hit = c;
      BR_CC:     hit = !c;
      BR_NEVER:  hit = 1'b0;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ex_skid_buffer.sv
// rtl/ex_skid_buffer.sv - in-order output buffer of one or two entries with valid/ready handshake and flush
module ex_skid_buffer #(
  parameter int W     = 20,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // slot0 is always the oldest entry and drives the output
  logic [1:0]   count;
  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         push;
  logic         pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = slot0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // Two-deep mode looks only at held state; one-deep mode passes downstream ready through
  always_comb begin
    in_ready = 1'b0;
    if (rst) begin
      in_ready = 1'b0;
    end else if (DEPTH >= 2) begin
      in_ready = (count != 2'd2);
    end else begin
      in_ready = (count == 2'd0) || out_ready;
    end
  end

  // Occupancy and slot shifting; flush wins over any push or pop
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            slot0 <= in_data;
          end else begin
            slot1 <= in_data;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= in_data;
          end else begin
            slot0 <= in_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_result_stage.sv
// rtl/ex_result_stage.sv - execute result stage: writeback buffering, flag commit and branch resolve; EX_RESULT_SKID_EN selects a 2-entry buffer
module ex_result_stage
  import simple_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int RA_W   = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic [3:0]        FLAG_IN,
  input  logic              FLAG_WE,
  input  logic [RA_W-1:0]   RD_ADDR,
  input  logic              RD_WE,
  input  logic              BR_EN,
  input  logic [2:0]        BR_COND,
  input  logic [DATA_W-1:0] BR_TARGET,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [RA_W-1:0]   OUT_RD,
  output logic              OUT_WE,
  output logic [3:0]        FLAG_REG,
  output logic              BR_TAKEN,
  output logic [DATA_W-1:0] BR_PC
);

  localparam int ENTRY_W = DATA_W + RA_W + 1;
`ifdef EX_RESULT_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic               accept;
  logic               br_hit;
  logic [ENTRY_W-1:0] out_entry;

  assign accept = IN_VALID && IN_READY && !FLUSH;
  // Condition uses the committed flags, before this entry's own flag write lands
  assign br_hit = accept && BR_EN && br_cond_true(BR_COND, FLAG_REG);

  ex_skid_buffer #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (CLK),
    .rst       (RST),
    .flush     (FLUSH),
    .in_valid  (IN_VALID),
    .in_ready  (IN_READY),
    .in_data   ({ALU_OUT, RD_ADDR, RD_WE}),
    .out_valid (OUT_VALID),
    .out_ready (OUT_READY),
    .out_data  (out_entry)
  );

  assign {OUT_DATA, OUT_RD, OUT_WE} = out_entry;

  // Flag commit and one-cycle branch pulse, independent of writeback backpressure
  always_ff @(posedge CLK) begin
    if (RST) begin
      FLAG_REG <= 4'd0;
      BR_TAKEN <= 1'b0;
      BR_PC    <= '0;
    end else begin
      BR_TAKEN <= br_hit;
      if (br_hit) begin
        BR_PC <= BR_TARGET;
      end
      if (accept && FLAG_WE) begin
        FLAG_REG <= FLAG_IN;
      end
    end
  end

endmodule

// File: tb/tb_ex_result_stage.sv
// tb/tb_ex_result_stage.sv - self-checking bench for ex_result_stage with a queue-based reference model
module tb_ex_result_stage;

  localparam int DATA_W = 16;
  localparam int RA_W   = 3;
`ifdef EX_RESULT_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid, in_ready, flag_we, rd_we, br_en, flush;
  logic              out_valid, out_ready, out_we, br_taken;
  logic [DATA_W-1:0] alu_out, br_target, out_data, br_pc;
  logic [3:0]        flag_in, flag_reg;
  logic [RA_W-1:0]   rd_addr, out_rd;
  logic [2:0]        br_cond;

  ex_result_stage #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .ALU_OUT(alu_out), .FLAG_IN(flag_in), .FLAG_WE(flag_we),
    .RD_ADDR(rd_addr), .RD_WE(rd_we), .BR_EN(br_en), .BR_COND(br_cond),
    .BR_TARGET(br_target), .FLUSH(flush), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .OUT_DATA(out_data), .OUT_RD(out_rd),
    .OUT_WE(out_we), .FLAG_REG(flag_reg), .BR_TAKEN(br_taken), .BR_PC(br_pc)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [RA_W-1:0]   rd;
    logic              we;
  } entry_t;

  entry_t            m_q[$];
  logic [3:0]        m_flags = 4'd0;
  logic              m_br_taken = 1'b0;
  logic [DATA_W-1:0] m_br_pc = '0;
  int tests = 0;
  int fails = 0;

  function automatic logic cond_hit(input logic [2:0] c, input logic [3:0] f);
    logic s, z, cy, v;
    s = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return s != v;
      3'd4: return z || (s != v);
      3'd5: return cy;
      3'd6: return !cy;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_ready();
    if (rst) return 1'b0;
    if (DEPTH == 2) return m_q.size() < 2;
    return (m_q.size() == 0) || out_ready;
  endfunction

  task automatic idle();
    in_valid = 0; flag_we = 0; flag_in = 0; rd_we = 0; rd_addr = 0;
    br_en = 0; br_cond = 0; br_target = 0; flush = 0; alu_out = 0;
  endtask

  task automatic offer(input logic [DATA_W-1:0] d, input logic [RA_W-1:0] r, input logic w);
    in_valid = 1; alu_out = d; rd_addr = r; rd_we = w; flag_we = 0; br_en = 0;
  endtask

  // Advance one clock, moving the reference model by the same edge
  task automatic tick();
    logic acc, pop, hit;
    entry_t e;
    acc = in_valid && m_ready() && !flush && !rst;
    pop = (m_q.size() > 0) && out_ready;
    hit = cond_hit(br_cond, m_flags);
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_flags = 0; m_br_taken = 0; m_br_pc = 0;
    end else if (flush) begin
      m_q.delete(); m_br_taken = 0;
    end else begin
      m_br_taken = acc && br_en && hit;
      if (m_br_taken) m_br_pc = br_target;
      if (acc && flag_we) m_flags = flag_in;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        e.data = alu_out; e.rd = rd_addr; e.we = rd_we;
        m_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); out_ready = 0; rst = 1;
    tick(); tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (out_we !== 1'b0) begin fails++; $display("FAIL reset_out_we: got %b want 0", out_we); end
    tests++; if (br_taken !== 1'b0) begin fails++; $display("FAIL reset_br_taken: got %b want 0", br_taken); end
    tests++; if (flag_reg !== 4'd0) begin fails++; $display("FAIL reset_flag_reg: got %h want 0", flag_reg); end
    tests++; if (out_data !== 16'd0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    tests++; if (out_rd !== 3'd0) begin fails++; $display("FAIL reset_out_rd: got %h want 0", out_rd); end
    tests++; if (br_pc !== 16'd0) begin fails++; $display("FAIL reset_br_pc: got %h want 0", br_pc); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    rst = 0; #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1; offer(16'h1234, 3'd5, 1'b1);
    tick(); idle();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    tests++; if (out_data !== 16'h1234) begin fails++; $display("FAIL basic_data: got %h want 1234", out_data); end
    tests++; if (out_rd !== 3'd5) begin fails++; $display("FAIL basic_rd: got %0d want 5", out_rd); end
    tests++; if (out_we !== 1'b1) begin fails++; $display("FAIL basic_we: got %b want 1", out_we); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_branch();
    out_ready = 1; offer(16'h0001, 3'd1, 1'b0); flag_we = 1; flag_in = 4'b0100;
    tick();
    offer(16'h0002, 3'd2, 1'b0); br_en = 1; br_cond = 3'd1; br_target = 16'h0040;
    tick(); idle();
    tests++; if (br_taken !== 1'b1) begin fails++; $display("FAIL branch_taken: got %b want 1", br_taken); end
    tests++; if (br_pc !== 16'h0040) begin fails++; $display("FAIL branch_pc: got %h want 0040", br_pc); end
    tick();
    tests++; if (br_taken !== 1'b0) begin fails++; $display("FAIL branch_pulse_end: got %b want 0", br_taken); end
    tests++; if (br_pc !== 16'h0040) begin fails++; $display("FAIL branch_pc_hold: got %h want 0040", br_pc); end
  endtask

  task automatic test_same_entry();
    out_ready = 1; offer(16'h0003, 3'd3, 1'b0); flag_we = 1; flag_in = 4'b0000;
    tick();
    tests++; if (flag_reg !== 4'b0000) begin fails++; $display("FAIL same_prior_flags: got %b want 0000", flag_reg); end
    offer(16'h0004, 3'd4, 1'b0); flag_we = 1; flag_in = 4'b0100;
    br_en = 1; br_cond = 3'd1; br_target = 16'h0080;
    tick(); idle();
    tests++; if (br_taken !== 1'b0) begin fails++; $display("FAIL same_no_branch: got %b want 0", br_taken); end
    tests++; if (flag_reg !== 4'b0100) begin fails++; $display("FAIL same_flags_after: got %b want 0100", flag_reg); end
    tests++; if (br_pc !== 16'h0040) begin fails++; $display("FAIL same_pc_hold: got %h want 0040", br_pc); end
    tick(); tick();
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] exp_d [3];
    exp_d[0] = 16'hA001; exp_d[1] = 16'hB002; exp_d[2] = 16'hC003;
    out_ready = 0;
    offer(exp_d[0], 3'd1, 1'b1); tick();
    offer(exp_d[1], 3'd2, 1'b1); tick();
    offer(exp_d[2], 3'd3, 1'b1); tick();
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    idle(); out_ready = 1; #1;
    for (int i = 0; i < DEPTH; i++) begin
      tests++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        fails++; $display("FAIL bp_order_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_d[i]);
      end
      tick();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_extra: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    offer(16'h5501, 3'd1, 1'b1); tick();
    offer(16'h5502, 3'd2, 1'b1); tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL flush_held: got %b want 1", out_valid); end
    offer(16'h5503, 3'd3, 1'b1); flush = 1; br_en = 1; br_cond = 3'd0;
    br_target = 16'h1111; flag_we = 1; flag_in = 4'b1011; out_ready = 1;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_empty: got %b want 0", out_valid); end
    tests++; if (br_taken !== 1'b0) begin fails++; $display("FAIL flush_no_branch: got %b want 0", br_taken); end
    tests++; if (flag_reg !== 4'b0100) begin fails++; $display("FAIL flush_flags: got %b want 0100", flag_reg); end
    tests++; if (br_pc !== 16'h0040) begin fails++; $display("FAIL flush_pc: got %h want 0040", br_pc); end
    idle(); tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_stays_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    offer(16'h7701, 3'd1, 1'b1); tick();
    offer(16'h7702, 3'd2, 1'b1); tick();
    rst = 1; offer(16'h7703, 3'd3, 1'b1);
    tick();
    tests++; if (out_valid !== 1'b0 || out_we !== 1'b0) begin fails++; $display("FAIL rstmid_valid_we: got %b%b want 00", out_valid, out_we); end
    tests++; if (out_data !== 16'd0 || out_rd !== 3'd0) begin fails++; $display("FAIL rstmid_data_rd: got %h/%0d want 0/0", out_data, out_rd); end
    tests++; if (br_taken !== 1'b0 || br_pc !== 16'd0) begin fails++; $display("FAIL rstmid_branch: got %b/%h want 0/0", br_taken, br_pc); end
    tests++; if (flag_reg !== 4'd0) begin fails++; $display("FAIL rstmid_flags: got %b want 0000", flag_reg); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
    rst = 0; out_ready = 1; offer(16'hD00D, 3'd6, 1'b1);
    tick(); idle();
    tests++; if (out_valid !== 1'b1 || out_data !== 16'hD00D || out_rd !== 3'd6) begin
      fails++; $display("FAIL rstmid_first_out: got v=%b d=%h rd=%0d want v=1 d=d00d rd=6", out_valid, out_data, out_rd);
    end
    tick();
  endtask

  task automatic test_random();
    logic exp_v;
    for (int n = 0; n < 400; n++) begin
      exp_v = (m_q.size() > 0);
      tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL rand_valid @%0d: got %b want %b", n, out_valid, exp_v); end
      if (exp_v) begin
        tests++; if ({out_data, out_rd, out_we} !== {m_q[0].data, m_q[0].rd, m_q[0].we}) begin
          fails++; $display("FAIL rand_entry @%0d: got %h/%0d/%b want %h/%0d/%b", n, out_data, out_rd, out_we, m_q[0].data, m_q[0].rd, m_q[0].we);
        end
      end
      tests++; if (flag_reg !== m_flags) begin fails++; $display("FAIL rand_flags @%0d: got %b want %b", n, flag_reg, m_flags); end
      tests++; if (br_taken !== m_br_taken) begin fails++; $display("FAIL rand_br_taken @%0d: got %b want %b", n, br_taken, m_br_taken); end
      tests++; if (br_pc !== m_br_pc) begin fails++; $display("FAIL rand_br_pc @%0d: got %h want %h", n, br_pc, m_br_pc); end
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(4) > 1);
      flush     = ($urandom_range(19) == 0);
      rst       = ($urandom_range(49) == 0);
      alu_out   = DATA_W'($urandom);
      rd_addr   = RA_W'($urandom);
      rd_we     = 1'($urandom);
      flag_we   = 1'($urandom);
      flag_in   = 4'($urandom);
      br_en     = 1'($urandom);
      br_cond   = 3'($urandom);
      br_target = DATA_W'($urandom);
      #1;
      tests++; if (in_ready !== m_ready()) begin fails++; $display("FAIL rand_in_ready @%0d: got %b want %b", n, in_ready, m_ready()); end
      tick();
    end
    rst = 0; idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_same_entry();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
